// File: rtl/wb_pkg.sv
// Shared writeback definitions: writeback source select and load funct3 codes.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword/word from the raw memory
// word and sign/zero-extends it. Flags halfword/word accesses at illegal offsets.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  assign selByte = rdata[8*offset +: 8];
  assign selHalf = offset[1] ? rdata[31:16] : rdata[15:0];

  // Size decode; misaligned or undefined accesses return zero.
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{selByte[7]}}, selByte};
      F3_LBU: data = {24'h0, selByte};
      F3_LH: begin
        misalign = offset[0];
        if (!offset[0]) data = {{16{selHalf[15]}}, selHalf};
      end
      F3_LHU: begin
        misalign = offset[0];
        if (!offset[0]) data = {16'h0, selHalf};
      end
      F3_LW: begin
        misalign = (offset != 2'b00);
        if (offset == 2'b00) data = rdata;
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback formatting and same-cycle forwarding.
// Raw fields are registered; alignment and source muxing are combinational.
// Optional retire counter (instret) is built when RETIRE_CNT_EN is defined.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          RST_VALID = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_wen,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_mem_rdata,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_wen,
  output logic            wb_valid,
  output logic            wb_misalign,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            fwd_hit
`ifdef RETIRE_CNT_EN
  ,
  output logic [63:0]     instret
`endif
);

  logic            validQ;
  logic            regWenQ;
  logic [4:0]      rdQ;
  wb_sel_e         selQ;
  logic [2:0]      funct3Q;
  logic [XLEN-1:0] aluQ;
  logic [XLEN-1:0] pc4Q;
  logic [XLEN-1:0] rdataQ;

  logic [XLEN-1:0] alignData;
  logic            alignMis;
  logic            loadMis;
  logic [XLEN-1:0] dataMux;

  // Stage register: reset > flush (bubble) > stall (hold) > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ  <= RST_VALID;
      regWenQ <= 1'b0;
      rdQ     <= '0;
      selQ    <= WB_ALU;
      funct3Q <= '0;
      aluQ    <= '0;
      pc4Q    <= '0;
      rdataQ  <= '0;
    end else if (flush_i) begin
      validQ  <= 1'b0;
      regWenQ <= 1'b0;
    end else if (!stall_i) begin
      validQ  <= in_valid;
      regWenQ <= in_reg_wen;
      rdQ     <= in_rd;
      selQ    <= wb_sel_e'(in_wb_sel);
      funct3Q <= in_funct3;
      aluQ    <= in_alu_result;
      pc4Q    <= in_pc_plus4;
      rdataQ  <= in_mem_rdata;
    end
  end

  load_align u_load_align (
    .rdata    (rdataQ),
    .offset   (aluQ[1:0]),
    .funct3   (funct3Q),
    .data     (alignData),
    .misalign (alignMis)
  );

  // Writeback source select; reserved select and misaligned loads yield zero.
  always_comb begin
    dataMux = '0;
    case (selQ)
      WB_ALU:  dataMux = aluQ;
      WB_MEM:  dataMux = alignMis ? '0 : alignData;
      WB_PC4:  dataMux = pc4Q;
      default: dataMux = '0;
    endcase
  end

  assign loadMis     = validQ & (selQ == WB_MEM) & alignMis;
  assign wb_addr     = rdQ;
  assign wb_data     = dataMux;
  assign wb_valid    = validQ;
  assign wb_misalign = loadMis;
  // x0 is hardwired: never issue a write to it.
  assign wb_wen      = validQ & regWenQ & (rdQ != 5'd0) & ~loadMis;

  assign fwd_rd   = wb_addr;
  assign fwd_data = wb_data;
  assign fwd_hit  = wb_wen;

`ifdef RETIRE_CNT_EN
  logic [63:0] instretQ;

  // Retire counter: counts every captured valid instruction, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instretQ <= '0;
    end else if (in_valid && !stall_i && !flush_i) begin
      instretQ <= instretQ + 64'd1;
    end
  end

  assign instret = instretQ;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (RETIRE_CNT_EN optional).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i, flush_i, in_valid, in_reg_wen;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_pc_plus4, in_mem_rdata;
  logic [4:0]  wb_addr, fwd_rd;
  logic [31:0] wb_data, fwd_data;
  logic        wb_wen, wb_valid, wb_misalign, fwd_hit;
`ifdef RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .in_valid      (in_valid),
    .in_rd         (in_rd),
    .in_reg_wen    (in_reg_wen),
    .in_wb_sel     (in_wb_sel),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_mem_rdata  (in_mem_rdata),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_wen        (wb_wen),
    .wb_valid      (wb_valid),
    .wb_misalign   (wb_misalign),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .fwd_hit       (fwd_hit)
`ifdef RETIRE_CNT_EN
    ,
    .instret       (instret)
`endif
  );

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] rdata);
    in_valid = v; in_rd = rd; in_reg_wen = wen; in_wb_sel = sel; in_funct3 = f3;
    in_alu_result = alu; in_pc_plus4 = pc4; in_mem_rdata = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({wb_valid, wb_wen, wb_misalign, fwd_hit} !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000", {wb_valid, wb_wen, wb_misalign, fwd_hit});
      failures++;
    end
    checks++;
    if (wb_addr !== 5'd0 || wb_data !== 32'h0) begin
      $display("FAIL reset_addr_data got=%0d/%h exp=0/00000000", wb_addr, wb_data);
      failures++;
    end
`ifdef RETIRE_CNT_EN
    checks++;
    if (instret !== 64'd0) begin
      $display("FAIL reset_instret got=%0d exp=0", instret);
      failures++;
    end
`endif
    step();
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd7, 1'b1, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0);
    step();
    stall_i = 1'b1;
    checks++;
    if (wb_wen !== 1'b1 || wb_data !== 32'h12345678) begin
      $display("FAIL async_pre got=%b/%h exp=1/12345678", wb_wen, wb_data);
      failures++;
    end
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wb_valid, wb_wen, fwd_hit, wb_misalign} !== 4'b0000 || wb_addr !== 5'd0 ||
        wb_data !== 32'h0 || fwd_rd !== 5'd0 || fwd_data !== 32'h0) begin
      $display("FAIL async_clear got=%b/%0d/%h exp=0000/0/00000000",
               {wb_valid, wb_wen, fwd_hit, wb_misalign}, wb_addr, wb_data);
      failures++;
    end
    #1 rst = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0);
    step();
    checks++;
    if (wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF || wb_wen !== 1'b1 || wb_valid !== 1'b1) begin
      $display("FAIL alu_write got=%0d/%h/%b exp=5/deadbeef/1", wb_addr, wb_data, wb_wen);
      failures++;
    end
    checks++;
    if (fwd_hit !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'hDEADBEEF) begin
      $display("FAIL alu_fwd got=%b/%0d/%h exp=1/5/deadbeef", fwd_hit, fwd_rd, fwd_data);
      failures++;
    end
    drive(1'b1, 5'd31, 1'b1, 2'b10, 3'b000, 32'h0, 32'h00001004, 32'h0);
    step();
    checks++;
    if (wb_data !== 32'h00001004 || wb_wen !== 1'b1 || wb_addr !== 5'd31) begin
      $display("FAIL pc4 got=%h/%b exp=00001004/1", wb_data, wb_wen);
      failures++;
    end
    drive(1'b1, 5'd8, 1'b1, 2'b11, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    checks++;
    if (wb_data !== 32'h0 || wb_wen !== 1'b1) begin
      $display("FAIL rsvd_sel got=%h/%b exp=00000000/1", wb_data, wb_wen);
      failures++;
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [1:0]  off[6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [31:0] exp[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                            32'h80FF7F01, 32'h0000007F};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd10, 1'b1, 2'b01, f3[i], {30'h400, off[i]}, 32'h0, 32'h80FF7F01);
      step();
      checks++;
      if (wb_data !== exp[i] || wb_misalign !== 1'b0 || wb_wen !== 1'b1) begin
        $display("FAIL load_%0d got=%h/%b/%b exp=%h/0/1", i, wb_data, wb_misalign, wb_wen, exp[i]);
        failures++;
      end
    end
    // Undefined load size returns zero but is not misaligned.
    drive(1'b1, 5'd10, 1'b1, 2'b01, 3'b011, 32'h0, 32'h0, 32'h80FF7F01);
    step();
    checks++;
    if (wb_data !== 32'h0 || wb_misalign !== 1'b0 || wb_wen !== 1'b1) begin
      $display("FAIL load_undef got=%h/%b/%b exp=00000000/0/1", wb_data, wb_misalign, wb_wen);
      failures++;
    end
  endtask

  task automatic test_misalign();
    logic [2:0] f3 [3] = '{3'b010, 3'b001, 3'b101};
    logic [1:0] off[3] = '{2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd12, 1'b1, 2'b01, f3[i], {30'h0, off[i]}, 32'h0, 32'h80FF7F01);
      step();
      checks++;
      if (wb_misalign !== 1'b1 || wb_wen !== 1'b0 || fwd_hit !== 1'b0 || wb_data !== 32'h0) begin
        $display("FAIL misalign_%0d got=%b/%b/%h exp=1/0/00000000", i, wb_misalign, wb_wen, wb_data);
        failures++;
      end
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 32'hCAFEF00D, 32'h0, 32'h0);
    step();
    checks++;
    if (wb_wen !== 1'b0 || wb_valid !== 1'b1 || fwd_hit !== 1'b0) begin
      $display("FAIL x0_write got=wen%b/valid%b exp=wen0/valid1", wb_wen, wb_valid);
      failures++;
    end
  endtask

  task automatic test_stall_flush();
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i + 5), 1'b1, 2'b00, 3'b000, {4{8'(i * 17)}}, 32'h0, 32'h0);
      step();
    end
    checks++;
    if (wb_addr !== 5'd9 || wb_data !== 32'h44444444) begin
      $display("FAIL pre_stall got=%0d/%h exp=9/44444444", wb_addr, wb_data);
      failures++;
    end
    stall_i = 1'b1;
    drive(1'b1, 5'd20, 1'b1, 2'b00, 3'b000, 32'h55555555, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (wb_addr !== 5'd9 || wb_data !== 32'h44444444 || wb_wen !== 1'b1 || wb_valid !== 1'b1) begin
        $display("FAIL stall_hold_%0d got=%0d/%h/%b exp=9/44444444/1", i, wb_addr, wb_data, wb_wen);
        failures++;
      end
    end
    flush_i = 1'b1;
    step();
    checks++;
    if (wb_valid !== 1'b0 || wb_wen !== 1'b0 || fwd_hit !== 1'b0) begin
      $display("FAIL stall_flush got=valid%b/wen%b exp=valid0/wen0", wb_valid, wb_wen);
      failures++;
    end
`ifdef RETIRE_CNT_EN
    checks++;
    if (instret !== 64'd4) begin
      $display("FAIL instret got=%0d exp=4", instret);
      failures++;
    end
`endif
    stall_i = 1'b0;
    flush_i = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_async_reset();
    test_alu();
    test_load();
    test_misalign();
    test_x0();
    test_stall_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
